// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : counter_arbiter
//  Description : Round-robin scheduler sharing one modulo up-counter among
//                N_REQ requesters. The owner runs for its latched slot
//                length in enabled ticks, receives a one-cycle done pulse,
//                and priority then rotates past it. Dropping the request
//                mid-slot aborts without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   len,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [WIDTH-1:0]         count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   count_q, count_d;
    // Terminal count value, i.e. effective slot length minus one.
    logic [WIDTH-1:0]   last_q,  last_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q,  done_d;
    logic               busy_q,  busy_d;

    // Round-robin selection results
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   sel_cand;
    int                 sel_scan;
    logic [WIDTH-1:0]   sel_len;
    logic [PTR_W-1:0]   owner_next;

    // Per-requester view of the flattened length bus
    logic [WIDTH-1:0]   len_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len_unpack
            assign len_arr[gi] = len[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Find the first requesting index at or after the rotating pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_cand  = '0;
        sel_scan  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_scan = (int'(ptr_q) + k) % N_REQ;
            sel_cand = PTR_W'(sel_scan);
            if (!sel_found && req[sel_cand]) begin
                sel_found = 1'b1;
                sel_idx   = sel_cand;
            end
        end
    end

    // Length of the selected requester and the pointer value that follows
    // the current owner.
    always_comb begin
        sel_len    = len_arr[sel_idx];
        owner_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        count_d = count_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d = S_RUN;
                    owner_d = sel_idx;
                    grant_d = N_REQ'(1) << sel_idx;
                    busy_d  = 1'b1;
                    count_d = '0;
                    // A zero length is treated as a one-tick slot.
                    last_d  = (sel_len == '0) ? '0 : sel_len - WIDTH'(1);
                end
            end

            S_RUN: begin
                if (!req[owner_q]) begin
                    // Abort wins over counting and over terminal detection.
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = owner_next;
                end else if (en) begin
                    if (count_q == last_q) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                ptr_d   = owner_next;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
            last_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_counter_arbiter
//  Description : Self-checking bench for counter_arbiter with a slot-level
//                reference model feeding a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    counter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         busy;
        logic [W-1:0] count;
    } snap_t;

    snap_t exp_q[$];
    int    done_ev_q[$];

    int errors;
    int checks;
    int dones_seen;

    // Reference model: owner index (-1 when free), ticks counted so far,
    // slot length in ticks, and whether the completion cycle is showing.
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_slot;
    int m_idx;
    bit m_pulse;

    initial begin : model
        snap_t s;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_slot = 1; m_pulse = 0; m_idx = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_owner = -1; m_ptr = 0; m_cnt = 0; m_pulse = 0;
            end else if (m_pulse) begin
                m_pulse = 0;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end else if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    m_idx = (m_ptr + k) % N;
                    if (m_owner < 0 && req[m_idx]) m_owner = m_idx;
                end
                if (m_owner >= 0) begin
                    m_slot = int'(len[m_owner*W +: W]);
                    if (m_slot == 0) m_slot = 1;
                    m_cnt = 0;
                end
            end else begin
                if (!req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt   = 0;
                end else if (en) begin
                    if (m_cnt + 1 == m_slot) begin
                        m_pulse = 1;
                        done_ev_q.push_back(m_owner);
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
            s.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            s.done  = m_pulse ? (N'(1) << m_owner) : '0;
            s.busy  = (m_owner >= 0);
            s.count = W'(m_cnt);
            exp_q.push_back(s);
        end
    end

    // Scoreboard monitor: compares every cycle's outputs and each done pulse.
    initial begin : monitor
        snap_t e;
        snap_t a;
        int    ow;
        errors = 0; checks = 0; dones_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            a = {grant, done, busy, count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot_underflow t=%0t: no expected entry for grant=%b", $time, grant);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                             $time, a.grant, a.done, a.busy, a.count, e.grant, e.done, e.busy, e.count);
                end
            end
            if (done !== '0) begin
                dones_seen++;
                checks++;
                if (done_ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected t=%0t: got done=%b, want no pulse", $time, done);
                end else begin
                    ow = done_ev_q.pop_front();
                    if (done !== (N'(1) << ow)) begin
                        errors++;
                        $display("FAIL done_owner t=%0t: got done=%b, want %b", $time, done, N'(1) << ow);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin : driver
        int  waited;
        reset = 1'b1;
        req   = '1;
        en    = 1'b1;
        len   = {N{W'(2)}};

        // Reset with all requests pending, then fairness rotation.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (24) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        // Single requester 2, length 5.
        len[2*W +: W] = W'(5);
        req = 4'b0100;
        repeat (10) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Requester 0, length 6, enable gap of 4 cycles mid-run.
        len[0 +: W] = W'(6);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Owner 1 aborts at count 3 while requester 2 waits.
        len[1*W +: W] = W'(8);
        len[2*W +: W] = W'(3);
        req = 4'b0110;
        waited = 0;
        while (!(m_owner == 1 && m_cnt == 3) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 30) begin
            errors++;
            $display("FAIL abort_setup: owner=%0d count=%0d, want owner=1 count=3", m_owner, m_cnt);
        end
        req = 4'b0100;
        repeat (10) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Zero length on requester 3.
        len[3*W +: W] = W'(0);
        req = 4'b1000;
        repeat (5) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a slot.
        len[0 +: W] = W'(8);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({grant, done, busy, count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b done=%b busy=%b count=%0d, want all zero",
                     grant, done, busy, count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);

        // Randomized traffic with sticky requests.
        req = '1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req = req ^ (N'(1) << b);
                if ($urandom_range(0, 7) == 0) len[b*W +: W] = W'($urandom_range(0, 15));
            end
            en = ($urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        req   = '0;
        repeat (5) @(negedge clk);

        checks++;
        if (done_ev_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing: got %0d unmatched expected pulses, want 0", done_ev_q.size());
        end
        checks++;
        if (dones_seen < 20) begin
            errors++;
            $display("FAIL done_activity: got %0d done pulses, want at least 20", dones_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Round-robin scheduler that shares one modulo up-counter (timer) among N_REQ requesters.
- Each requester asks for a timed slot of a programmed length; the block grants the counter to one requester at a time and runs it for that many enabled ticks.
- Signals completion with a one-cycle done pulse to the owner, then rotates priority.
- Sits between client FSMs needing delays and the shared counter datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter and slot-length width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when 0 the running counter holds its value.
- req  input  N_REQ  per-requester request level; must stay high until done or it aborts.
- len  input  N_REQ*WIDTH  flattened slot lengths; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot owner of the counter; all zero when idle.
- done  output  N_REQ  one-cycle completion pulse to the owner.
- busy  output  1  high in RUN or DONE.
- count  output  WIDTH  current shared counter value.

Behaviour:
- Reset (async, any time, including mid-slot): state=IDLE, grant=0, done=0, busy=0, count=0, rr pointer=0.
- FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - If any req is high, select the first requester at index >= ptr, wrapping modulo N_REQ.
  - Next cycle: grant one-hot = selected, latch L = len[selected], count=0, state=RUN.
  - If L==0, use L_eff=1; otherwise L_eff=L.
  - If req==0, stay in IDLE.
- RUN:
  - If req[owner]==0: abort. Next state IDLE, grant=0, no done pulse, ptr=owner+1 mod N_REQ, count=0.
  - Else if en==0: hold count.
  - Else if count==L_eff-1: state=DONE (count holds).
  - Else: count=count+1.
  - Abort has priority over counting and over reaching terminal.
- DONE (exactly 1 cycle): done[owner]=1, grant still = owner, busy=1. Next state IDLE, grant=0, ptr=owner+1 mod N_REQ, count=0.
- Latency, req sampled high in IDLE at edge t:
  - grant visible after t.
  - RUN occupies L_eff enabled cycles.
  - done is high for the single cycle after the terminal count.
  - Next grant is no earlier than 2 cycles after done.
- Latched length: len changes during RUN are ignored.
- Requests arriving while busy wait; there is no queueing beyond the req levels.
- Fairness: with all requesters continuously high, grants rotate 0,1,2,...,N_REQ-1,0.
- Count never exceeds 2^WIDTH-1. L=2^WIDTH-1 runs count from 0 to 2^WIDTH-2.
- Invariants: grant is one-hot or zero; done is a subset of grant; done and abort never occur in the same slot.

Test Plan:
- Reset high 3 cycles with req=4'b1111 -> grant=0, done=0, count=0 throughout. Release -> grant=4'b0001 on the next edge.
- req=4'b0100, len[2]=5, en=1 -> grant=4'b0100; count 0,1,2,3,4; done=4'b0100 for 1 cycle; then grant=0.
- req=4'b1111, all len=2, held high -> grant order 0001,0010,0100,1000,0001; four done pulses in the same order.
- req=4'b0001, len[0]=6, en toggled 0 for 4 cycles mid-run -> count holds during the gap; done fires 4 cycles later than the en=1 case.
- Owner 1 running (len=8), req[1] dropped at count=3 -> next cycle grant=0, no done; with req[2] pending, grant=4'b0100 the following IDLE cycle.
- len[3]=0 -> one RUN cycle at count=0, then done=4'b1000. Separately, assert reset during RUN -> grant, count and busy all 0 immediately (async).
